// File: rtl/disp_pkg.sv
// Shared constants and types for the six-digit seven-segment scan driver.
package disp_pkg;
  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [5:0] AN_OFF     = 6'b111111;

  typedef logic [2:0] digit_idx_t;

  // Active-low anode pattern with only the selected digit driven.
  function automatic logic [5:0] an_sel_n(digit_idx_t i);
    return ~(6'b000001 << i);
  endfunction
endpackage

// File: rtl/disp_mux6_if.sv
// Display bus: six segment patterns in, scanned anode/segment lines out.
// With DISP_MUX6_DIM_EN defined the bus also carries a 4-bit brightness duty.
interface disp_mux6_if;
  logic [7:0] in0, in1, in2, in3, in4, in5;
`ifdef DISP_MUX6_DIM_EN
  logic [3:0] duty;
`endif
  logic [5:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

`ifdef DISP_MUX6_DIM_EN
  modport master (output in0, in1, in2, in3, in4, in5, duty,
                  input  an, sseg, frame_tick);
  modport slave  (input  in0, in1, in2, in3, in4, in5, duty,
                  output an, sseg, frame_tick);
`else
  modport master (output in0, in1, in2, in3, in4, in5,
                  input  an, sseg, frame_tick);
  modport slave  (input  in0, in1, in2, in3, in4, in5,
                  output an, sseg, frame_tick);
`endif
endinterface

// File: rtl/disp_slot_timer.sv
// Slot counter and digit index for the display scan; flags the blanking
// guard at the start of each slot and the last cycle of each slot.
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter  int ticks_per_digit = 100_000,
  parameter  int blank_ticks     = 1_000,
  localparam int CW              = $clog2(ticks_per_digit)
) (
  input  logic       clk,
  input  logic       rst_n,
  output digit_idx_t idx,
  output logic       blank,
  output logic       wrap
);
  logic [CW-1:0] cnt;

  assign wrap = (cnt == CW'(ticks_per_digit - 1));

  generate
    if (blank_ticks == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt < CW'(blank_ticks));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // An out-of-range index can only come from an upset; recover at once.
      if (idx >= digit_idx_t'(NUM_DIGITS))
        idx <= '0;
      else if (wrap)
        idx <= (idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : idx + 3'd1;
    end
  end
endmodule

// File: rtl/disp_mux6.sv
// Six-digit multiplexed seven-segment driver with registered outputs.
// Optional DISP_MUX6_DIM_EN adds PWM dimming driven by bus.duty.
module disp_mux6
  import disp_pkg::*;
#(
  parameter int ticks_per_digit = 100_000,
  parameter int blank_ticks     = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  disp_mux6_if.slave  bus
);
  digit_idx_t idx;
  logic       blank, wrap, lit;
  logic       frame_pend;
  logic [5:0] an_q;
  logic [7:0] sseg_q;
  logic       frame_q;
  logic [NUM_DIGITS-1:0][7:0] digs;

  disp_slot_timer #(
    .ticks_per_digit (ticks_per_digit),
    .blank_ticks     (blank_ticks)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx),
    .blank (blank),
    .wrap  (wrap)
  );

  assign digs = {bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};

`ifdef DISP_MUX6_DIM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= '0;
    else        pwm <= pwm + 4'd1;
  end

  // Full duty bypasses the compare so 4'hF is truly always-on.
  assign lit = !blank && ((bus.duty == 4'hF) || (pwm < bus.duty));
`else
  assign lit = !blank;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= AN_OFF;
      sseg_q     <= SSEG_BLANK;
      frame_q    <= 1'b0;
      frame_pend <= 1'b0;
    end else begin
      // Pending flag delays the tick so it lines up with the registered outputs.
      frame_pend <= wrap && (idx == digit_idx_t'(NUM_DIGITS - 1));
      frame_q    <= frame_pend;
      if (lit && (idx < digit_idx_t'(NUM_DIGITS))) begin
        an_q   <= an_sel_n(idx);
        sseg_q <= digs[idx];
      end else begin
        an_q   <= AN_OFF;
        sseg_q <= SSEG_BLANK;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = frame_q;
endmodule

// File: tb/tb_disp_mux6.sv
// Randomized bench for disp_mux6: two instances (blank guard 2 and 0)
// compared each cycle against a slot/position model derived from cycle count.
module tb_disp_mux6;
  localparam int T = 10;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] pat [6];
  int vecs = 0;
  int errs = 0;
  int k;

  disp_mux6_if bus ();
  disp_mux6_if bus0 ();

  assign bus.in0 = pat[0];  assign bus0.in0 = pat[0];
  assign bus.in1 = pat[1];  assign bus0.in1 = pat[1];
  assign bus.in2 = pat[2];  assign bus0.in2 = pat[2];
  assign bus.in3 = pat[3];  assign bus0.in3 = pat[3];
  assign bus.in4 = pat[4];  assign bus0.in4 = pat[4];
  assign bus.in5 = pat[5];  assign bus0.in5 = pat[5];
`ifdef DISP_MUX6_DIM_EN
  assign bus.duty  = 4'hF;
  assign bus0.duty = 4'hF;
`endif

  disp_mux6 #(.ticks_per_digit(T), .blank_ticks(B)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  disp_mux6 #(.ticks_per_digit(T), .blank_ticks(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // Output after edge k shows the state reached after k-1 edges since release.
  function automatic logic [5:0] m_an(int t, int b);
    if (t % T < b) return 6'h3F;
    return ~(6'd1 << ((t / T) % 6));
  endfunction

  function automatic logic [7:0] m_sseg(int t, int b);
    if (t % T < b) return 8'hFF;
    return pat[(t / T) % 6];
  endfunction

  function automatic logic m_ft(int t);
    return (t > 0) && (t % (6 * T) == 0);
  endfunction

  task automatic chk_reset();
    chk("rst_an",   bus.an,          6'h3F);
    chk("rst_sseg", bus.sseg,        8'hFF);
    chk("rst_ft",   bus.frame_tick,  1'b0);
    chk("rst_an0",  bus0.an,         6'h3F);
    chk("rst_ss0",  bus0.sseg,       8'hFF);
  endtask

  task automatic step();
    int t;
    @(negedge clk);
    k++;
    t = k - 1;
    chk("an",    bus.an,          m_an(t, B));
    chk("sseg",  bus.sseg,        m_sseg(t, B));
    chk("ft",    bus.frame_tick,  m_ft(t));
    chk("an0",   bus0.an,         m_an(t, 0));
    chk("sseg0", bus0.sseg,       m_sseg(t, 0));
    chk("ft0",   bus0.frame_tick, m_ft(t));
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) pat[$urandom_range(5)] = 8'($urandom);
      step();
    end
  endtask

  initial begin
    logic found;
    k = 0;
    pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_reset();
    end

    rst_n = 1'b1;
    k = 0;
    repeat (75) step();

    // Upstream change mid-slot 2 must show up one cycle later.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if ((k / T) % 6 == 2 && k % T == 5) found = 1'b1;
      else step();
    end
    chk("slot2_reach", found, 1'b1);
    pat[2] = 8'h80;
    step();
    chk("in2_sseg", bus.sseg, 8'h80);
    chk("in2_an",   bus.an,   6'h3B);

    rand_cycles(200);

    // Asynchronous reset during the lit part of slot 4.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if ((k / T) % 6 == 4 && k % T == 5) found = 1'b1;
      else step();
    end
    chk("slot4_reach", found, 1'b1);
    chk("slot4_lit", bus.an, 6'h2F);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    k = 0;
    rand_cycles(140);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
